// File: rtl/multi_alarm_clock.sv
`default_nettype none
// multi_alarm_clock -- 24h BCD clock with NUM_ALARMS alarm slots, snooze and timed ring.
// Revision 1.0
module multi_alarm_clock #(
  parameter int CLK_DIV    = 10,
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60,
  localparam int AW        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            H_in1,
  input  logic [3:0]            H_in0,
  input  logic [3:0]            M_in1,
  input  logic [3:0]            M_in0,
  input  logic                  LD_time,
  input  logic                  LD_alarm,
  input  logic [AW-1:0]         al_sel,
  input  logic [NUM_ALARMS-1:0] AL_ON,
  input  logic                  STOP_al,
  input  logic                  SNOOZE,
  output logic                  Alarm,
  output logic [AW-1:0]         alarm_src,
  output logic [1:0]            H_out1,
  output logic [3:0]            H_out0,
  output logic [3:0]            M_out1,
  output logic [3:0]            M_out0,
  output logic [3:0]            S_out1,
  output logic [3:0]            S_out0,
  output logic                  sec_pulse
);

  localparam int PW        = $clog2(CLK_DIV);
  localparam int RW        = $clog2(RING_SEC + 1);
  localparam int SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int SW        = $clog2(SNZ_TICKS + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SEC - 1);
  localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNZ_TICKS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_t;

  logic [PW-1:0]         presc;
  logic                  tick;
  logic                  ld_valid;
  logic                  ld_time_ok;
  logic                  ld_alarm_ok;
  logic [1:0]            h1_nx;
  logic [3:0]            h0_nx, m1_nx, m0_nx, s1_nx, s0_nx;
  logic [13:0]           slot [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match;
  logic                  match_any;
  logic [AW-1:0]         match_idx;
  logic                  src_on;

  state_t                state, state_nx;
  logic [RW-1:0]         ring_cnt, ring_cnt_nx;
  logic [SW-1:0]         snz_cnt, snz_cnt_nx;
  logic [AW-1:0]         src_nx;

  assign tick      = (presc == PRESC_MAX);
  assign sec_pulse = tick;

  always_comb begin
    ld_valid = (H_in0 <= 4'd9) && (M_in1 <= 4'd5) && (M_in0 <= 4'd9) &&
               ((H_in1 < 2'd2) || ((H_in1 == 2'd2) && (H_in0 <= 4'd3)));
  end

  assign ld_time_ok  = LD_time  && ld_valid;
  assign ld_alarm_ok = LD_alarm && ld_valid;

  // BCD successor of the current time, rippling the carry digit by digit
  always_comb begin
    h1_nx = H_out1;
    h0_nx = H_out0;
    m1_nx = M_out1;
    m0_nx = M_out0;
    s1_nx = S_out1;
    s0_nx = S_out0;
    if (S_out0 != 4'd9) begin
      s0_nx = S_out0 + 4'd1;
    end else begin
      s0_nx = 4'd0;
      if (S_out1 != 4'd5) begin
        s1_nx = S_out1 + 4'd1;
      end else begin
        s1_nx = 4'd0;
        if (M_out0 != 4'd9) begin
          m0_nx = M_out0 + 4'd1;
        end else begin
          m0_nx = 4'd0;
          if (M_out1 != 4'd5) begin
            m1_nx = M_out1 + 4'd1;
          end else begin
            m1_nx = 4'd0;
            if ((H_out1 == 2'd2) && (H_out0 == 4'd3)) begin
              h1_nx = 2'd0;
              h0_nx = 4'd0;
            end else if (H_out0 == 4'd9) begin
              h0_nx = 4'd0;
              h1_nx = H_out1 + 2'd1;
            end else begin
              h0_nx = H_out0 + 4'd1;
            end
          end
        end
      end
    end
  end

  // A time load overrides the tick, so it can never produce a match
  always_comb begin
    match     = '0;
    match_any = 1'b0;
    match_idx = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match[i] = tick && !ld_time_ok && AL_ON[i] &&
                 (s1_nx == 4'd0) && (s0_nx == 4'd0) &&
                 (slot[i] == {h1_nx, h0_nx, m1_nx, m0_nx});
    end
    match_any = |match;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (match[i]) match_idx = AW'(i);
    end
  end

  always_comb begin
    src_on = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (alarm_src == AW'(i)) src_on = AL_ON[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc  <= '0;
      H_out1 <= 2'd0;
      H_out0 <= 4'd0;
      M_out1 <= 4'd0;
      M_out0 <= 4'd0;
      S_out1 <= 4'd0;
      S_out0 <= 4'd0;
    end else if (ld_time_ok) begin
      presc  <= '0;
      H_out1 <= H_in1;
      H_out0 <= H_in0;
      M_out1 <= M_in1;
      M_out0 <= M_in0;
      S_out1 <= 4'd0;
      S_out0 <= 4'd0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        H_out1 <= h1_nx;
        H_out0 <= h0_nx;
        M_out1 <= m1_nx;
        M_out0 <= m0_nx;
        S_out1 <= s1_nx;
        S_out0 <= s0_nx;
      end
    end
  end

  // Out-of-range al_sel matches no slot and is therefore ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (ld_alarm_ok && (al_sel == AW'(i))) begin
          slot[i] <= {H_in1, H_in0, M_in1, M_in0};
        end
      end
    end
  end

  always_comb begin
    state_nx    = state;
    ring_cnt_nx = ring_cnt;
    snz_cnt_nx  = snz_cnt;
    src_nx      = alarm_src;
    unique case (state)
      IDLE: begin
        if (match_any) begin
          state_nx    = RINGING;
          src_nx      = match_idx;
          ring_cnt_nx = '0;
        end
      end
      RINGING: begin
        if (STOP_al || !src_on) begin
          state_nx = IDLE;
        end else if (SNOOZE) begin
          state_nx   = SNOOZED;
          snz_cnt_nx = SNZ_LOAD;
        end else if (tick) begin
          if (ring_cnt == RING_LAST) state_nx = IDLE;
          else ring_cnt_nx = ring_cnt + 1'b1;
        end
      end
      SNOOZED: begin
        if (STOP_al || !src_on) begin
          state_nx = IDLE;
        end else if (tick) begin
          if (snz_cnt == SW'(1)) begin
            state_nx    = RINGING;
            ring_cnt_nx = '0;
            snz_cnt_nx  = '0;
          end else begin
            snz_cnt_nx = snz_cnt - 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ring_cnt  <= '0;
      snz_cnt   <= '0;
      alarm_src <= '0;
      Alarm     <= 1'b0;
    end else begin
      state     <= state_nx;
      ring_cnt  <= ring_cnt_nx;
      snz_cnt   <= snz_cnt_nx;
      alarm_src <= src_nx;
      Alarm     <= (state_nx == RINGING);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_alarm_clock.sv
`default_nettype none
// tb_multi_alarm_clock -- directed + random stimulus against a seconds-of-day reference model.
module tb_multi_alarm_clock;

  localparam int CLK_DIV    = 4;
  localparam int NUM_ALARMS = 4;
  localparam int SNOOZE_MIN = 1;
  localparam int RING_SEC   = 5;
  localparam int AW         = 2;

  logic                  clk      = 1'b0;
  logic                  reset    = 1'b0;
  logic [1:0]            H_in1    = '0;
  logic [3:0]            H_in0    = '0;
  logic [3:0]            M_in1    = '0;
  logic [3:0]            M_in0    = '0;
  logic                  LD_time  = 1'b0;
  logic                  LD_alarm = 1'b0;
  logic [AW-1:0]         al_sel   = '0;
  logic [NUM_ALARMS-1:0] AL_ON    = '0;
  logic                  STOP_al  = 1'b0;
  logic                  SNOOZE   = 1'b0;
  logic                  Alarm;
  logic [AW-1:0]         alarm_src;
  logic [1:0]            H_out1;
  logic [3:0]            H_out0, M_out1, M_out0, S_out1, S_out0;
  logic                  sec_pulse;

  multi_alarm_clock #(
    .CLK_DIV(CLK_DIV), .NUM_ALARMS(NUM_ALARMS),
    .SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)
  ) dut (
    .clk(clk), .reset(reset),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .al_sel(al_sel), .AL_ON(AL_ON),
    .STOP_al(STOP_al), .SNOOZE(SNOOZE),
    .Alarm(Alarm), .alarm_src(alarm_src),
    .H_out1(H_out1), .H_out0(H_out0), .M_out1(M_out1), .M_out0(M_out0),
    .S_out1(S_out1), .S_out0(S_out0), .sec_pulse(sec_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int tsec;
    int alarm;
    int src;
    int pulse;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: time as seconds of day, alarms as minute of day,
  // mode 0=idle 1=ringing 2=snoozed
  int m_tsec, m_cyc, m_mode, m_src, m_rang, m_left;
  int m_slot [NUM_ALARMS];

  always @(posedge clk) begin
    int   hr, mn, srcon, hit, idx;
    bit   ldv, tick;
    exp_t e;
    if (!reset) begin
      m_tsec = 0; m_cyc = 0; m_mode = 0; m_src = 0; m_rang = 0; m_left = 0;
      for (int i = 0; i < NUM_ALARMS; i++) m_slot[i] = 0;
    end else begin
      tick = (m_cyc == CLK_DIV - 1);
      hr   = int'(H_in1) * 10 + int'(H_in0);
      mn   = int'(M_in1) * 10 + int'(M_in0);
      ldv  = (H_in0 <= 9) && (M_in0 <= 9) && (M_in1 <= 9) && (hr <= 23) && (mn <= 59);
      hit  = 0;
      idx  = 0;
      if (LD_time && ldv) begin
        m_tsec = hr * 3600 + mn * 60;
        m_cyc  = 0;
      end else begin
        m_cyc = (m_cyc + 1) % CLK_DIV;
        if (tick) begin
          m_tsec = (m_tsec + 1) % 86400;
          if (m_tsec % 60 == 0) begin
            for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
              if (AL_ON[i] && m_slot[i] == m_tsec / 60) begin
                hit = 1;
                idx = i;
              end
            end
          end
        end
      end
      srcon = AL_ON[m_src];
      if (m_mode == 0) begin
        if (hit != 0) begin
          m_mode = 1; m_src = idx; m_rang = 0;
        end
      end else if (STOP_al || srcon == 0) begin
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (SNOOZE) begin
          m_mode = 2; m_left = SNOOZE_MIN * 60;
        end else if (tick) begin
          m_rang++;
          if (m_rang == RING_SEC) m_mode = 0;
        end
      end else if (tick) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 1; m_rang = 0;
        end
      end
      if (LD_alarm && ldv && int'(al_sel) < NUM_ALARMS) m_slot[al_sel] = hr * 60 + mn;
    end
    e.tsec  = m_tsec;
    e.alarm = (m_mode == 1) ? 1 : 0;
    e.src   = m_src;
    e.pulse = (m_cyc == CLK_DIV - 1) ? 1 : 0;
    exp_q.push_back(e);
  end

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   dt;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!reset) begin
        e.tsec = 0; e.alarm = 0; e.src = 0; e.pulse = 0;
      end
      dt = (int'(H_out1) * 10 + int'(H_out0)) * 3600 +
           (int'(M_out1) * 10 + int'(M_out0)) * 60 +
           int'(S_out1) * 10 + int'(S_out0);
      check("time_sec", dt, e.tsec);
      check("Alarm", int'(Alarm), e.alarm);
      check("alarm_src", int'(alarm_src), e.src);
      check("sec_pulse", int'(sec_pulse), e.pulse);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic ticks(input int n);
    step(n * CLK_DIV);
  endtask

  task automatic set_hm(input int h1, input int h0, input int m1, input int m0);
    H_in1 = 2'(h1);
    H_in0 = 4'(h0);
    M_in1 = 4'(m1);
    M_in0 = 4'(m0);
  endtask

  task automatic load_time(input int h1, input int h0, input int m1, input int m0);
    set_hm(h1, h0, m1, m0);
    LD_time = 1'b1;
    step(1);
    LD_time = 1'b0;
  endtask

  task automatic load_alarm(input int s, input int h1, input int h0, input int m1, input int m0);
    set_hm(h1, h0, m1, m0);
    al_sel   = AW'(s);
    LD_alarm = 1'b1;
    step(1);
    LD_alarm = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    int  r;
    bit  was_reset;
    step(3);
    reset = 1'b1;
    step(2);

    // midnight rollover with sec_pulse cadence
    AL_ON = 4'b0000;
    load_time(2, 3, 5, 9);
    ticks(62);

    // single slot rings, then times out
    load_alarm(2, 0, 7, 3, 1);
    AL_ON = 4'b0100;
    load_time(0, 7, 3, 0);
    ticks(68);

    // two slots at the same minute, stop together with snooze
    load_alarm(1, 0, 6, 0, 0);
    load_alarm(3, 0, 6, 0, 0);
    AL_ON = 4'b1010;
    load_time(0, 5, 5, 9);
    ticks(61);
    STOP_al = 1'b1;
    SNOOZE  = 1'b1;
    step(1);
    STOP_al = 1'b0;
    SNOOZE  = 1'b0;
    ticks(3);

    // snooze then re-ring with the same source
    load_time(0, 5, 5, 9);
    ticks(61);
    SNOOZE = 1'b1;
    step(1);
    SNOOZE = 1'b0;
    ticks(68);

    // invalid loads are ignored, loading straight onto the alarm time never rings
    load_time(2, 5, 0, 0);
    load_time(1, 2, 3, 10);
    load_alarm(0, 2, 4, 0, 0);
    load_alarm(0, 1, 0, 6, 0);
    load_time(0, 6, 0, 0);
    ticks(5);

    // reset in the middle of a snooze abandons the alarm
    load_time(0, 5, 5, 9);
    ticks(61);
    SNOOZE = 1'b1;
    step(1);
    SNOOZE = 1'b0;
    ticks(10);
    reset = 1'b0;
    step(1);
    reset = 1'b1;
    ticks(70);

    // randomized traffic biased around 12:00
    was_reset = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      reset    = 1'b1;
      LD_time  = 1'b0;
      LD_alarm = 1'b0;
      STOP_al  = 1'b0;
      SNOOZE   = 1'b0;
      r = $urandom_range(0, 999);
      if (r < 3) begin
        if ($urandom_range(0, 3) == 0) begin
          set_hm($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        end else if ($urandom_range(0, 3) == 0) begin
          set_hm(1, 1, 5, 9);
        end else begin
          set_hm(1, 2, 0, $urandom_range(0, 2));
        end
        LD_time = 1'b1;
      end else if (r < 13) begin
        al_sel = AW'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) begin
          set_hm($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        end else begin
          set_hm(1, 2, 0, $urandom_range(0, 3));
        end
        LD_alarm = 1'b1;
      end else if (r < 18) begin
        STOP_al = 1'b1;
      end else if (r < 40) begin
        SNOOZE = 1'b1;
      end else if (r < 44) begin
        AL_ON = NUM_ALARMS'($urandom_range(0, 15));
      end else if (r == 44 && !was_reset) begin
        reset = 1'b0;
      end
      was_reset = !reset;
      step(1);
    end
    reset    = 1'b1;
    LD_time  = 1'b0;
    LD_alarm = 1'b0;
    STOP_al  = 1'b0;
    SNOOZE   = 1'b0;
    step(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
